// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Requester identities. These also tag in-flight reads.
  typedef enum logic [1:0] {
    REQ_DBG  = 2'd0,
    REQ_DATA = 2'd1,
    REQ_IF   = 2'd2,
    REQ_NONE = 2'd3
  } req_id_e;

  // Debug lock state machine.
  typedef enum logic [1:0] {
    ARB    = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Full-word byte enable used for fetch and debug accesses.
  localparam logic [3:0] BE_ALL = 4'hF;

  // Supported SRAM read latency range.
  localparam int unsigned MIN_READ_LATENCY = 1;
  localparam int unsigned MAX_READ_LATENCY = 4;

  // One entry of the read response tag pipe.
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rsp_tag_t;

  localparam rsp_tag_t TAG_EMPTY = '{valid: 1'b0, id: REQ_NONE};

  // True when a tag carries a live response for the given requester.
  function automatic logic tag_is(input rsp_tag_t tag, input req_id_e id);
    return tag.valid && (tag.id == id);
  endfunction

endpackage

// File: rtl/rsp_tag_pipe.sv
// Shift register tracking which requester owns each in-flight SRAM read.
// The head entry lines up with the cycle mem_rdata is valid for that read.
module rsp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t push_tag_i,
  output rsp_tag_t head_o,
  output logic     inflight_any_o
);

  rsp_tag_t tag_q [Depth];
  rsp_tag_t tag_d [Depth];

  // Next-state: new tag enters stage 0, everything else moves one stage on.
  always_comb begin
    tag_d[0] = push_tag_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Tag storage; reset discards every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        tag_q[i] <= TAG_EMPTY;
      end
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign head_o = tag_q[Depth-1];

  // Reads still outstanding after this cycle; the head retires now so it is excluded.
  always_comb begin
    inflight_any_o = 1'b0;
    for (int unsigned i = 0; i + 1 < Depth; i++) begin
      inflight_any_o = inflight_any_o | tag_q[i].valid;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch, the MEM stage and
// the debug loader. Fixed priority dbg > data > fetch with a starvation guard
// for fetch, plus a debug lock mode that drains reads and then owns the memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_WAIT     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // Fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  // MEM-stage port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  // Debug loader port
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  // Shared read data and hazard unit hook
  output logic [DW-1:0] rdata,
  output logic          pipe_stall,
  // SRAM
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("mem_port_arbiter: READ_LATENCY must be within 1..4");
  end

  localparam int unsigned CntW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] WaitMax = CntW'(MAX_WAIT);

  arb_state_e     state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  req_id_e        win;
  rsp_tag_t       push_tag;
  rsp_tag_t       head_tag;
  logic           inflight_any;
  logic           pipe_empty_next;

  // Winner selection; nothing is granted while reset is asserted.
  always_comb begin
    win = REQ_NONE;
    if (rst_n) begin
      unique case (state_q)
        ARB: begin
          if (dbg_req) begin
            win = REQ_DBG;
          end else if (if_req && (starve_q == WaitMax)) begin
            // Starved fetch jumps ahead of data, never ahead of debug.
            win = REQ_IF;
          end else if (d_req) begin
            win = REQ_DATA;
          end else if (if_req) begin
            win = REQ_IF;
          end
        end
        LOCKED: begin
          if (dbg_req) begin
            win = REQ_DBG;
          end
        end
        default: win = REQ_NONE;
      endcase
    end
  end

  assign dbg_gnt = (win == REQ_DBG);
  assign d_gnt   = (win == REQ_DATA);
  assign if_gnt  = (win == REQ_IF);

  // SRAM request mux driven from the winner; idle bus is all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (win)
      REQ_DBG: begin
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_be    = BE_ALL;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      REQ_DATA: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      REQ_IF: begin
        mem_en   = 1'b1;
        mem_be   = BE_ALL;
        mem_addr = if_addr;
      end
      default: ;
    endcase
  end

  // Only reads are tracked; writes produce no response.
  always_comb begin
    push_tag       = TAG_EMPTY;
    push_tag.valid = mem_en && !mem_we;
    push_tag.id    = win;
  end

  rsp_tag_pipe #(
    .Depth(READ_LATENCY)
  ) u_tag_pipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_tag_i     (push_tag),
    .head_o         (head_tag),
    .inflight_any_o (inflight_any)
  );

  assign dbg_rvalid = tag_is(head_tag, REQ_DBG);
  assign d_rvalid   = tag_is(head_tag, REQ_DATA);
  assign if_rvalid  = tag_is(head_tag, REQ_IF);
  assign rdata      = mem_rdata;

  // Starvation counter next-state: count denied fetch cycles, saturate at MAX_WAIT.
  always_comb begin
    starve_d = '0;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == WaitMax) ? starve_q : starve_q + 1'b1;
    end
  end

  // No read will be outstanding after this cycle, counting one granted now.
  assign pipe_empty_next = !inflight_any && !push_tag.valid;

  // Debug lock state machine next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB: begin
        if (dbg_lock) begin
          state_d = pipe_empty_next ? LOCKED : DRAIN;
        end
      end
      DRAIN: begin
        if (!dbg_lock) begin
          state_d = ARB;
        end else if (!inflight_any) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (!dbg_lock) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Freeze the pipeline while memory is unavailable to it.
  always_comb begin
    pipe_stall = 1'b0;
    if (rst_n) begin
      if (state_q != ARB) begin
        pipe_stall = 1'b1;
      end else begin
        pipe_stall = (if_req && !if_gnt) || (d_req && !d_gnt);
      end
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiter instances (read latency 1 and 2) share one
// stimulus stream, each with its own behavioural SRAM and response scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam logic [2:0] G_NO  = 3'b000;
  localparam logic [2:0] G_IF  = 3'b001;
  localparam logic [2:0] G_D   = 3'b010;
  localparam logic [2:0] G_DBG = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req, d_req, d_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] if_addr, d_addr, dbg_addr;
  logic [3:0]    d_be;
  logic [DW-1:0] d_wdata, dbg_wdata;

  logic [1:0]         if_gnt, if_rvalid, d_gnt, d_rvalid, dbg_gnt, dbg_rvalid;
  logic [1:0]         pipe_stall, mem_en, mem_we;
  logic [1:0][3:0]    mem_be;
  logic [1:0][AW-1:0] mem_addr;
  logic [1:0][DW-1:0] rdata, mem_wdata, mem_rdata;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int unsigned RL = k + 1;

    mem_port_arbiter #(
      .AW(AW), .DW(DW), .READ_LATENCY(RL), .MAX_WAIT(4)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt[k]),
      .if_rvalid  (if_rvalid[k]),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_be       (d_be),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt[k]),
      .d_rvalid   (d_rvalid[k]),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_lock   (dbg_lock),
      .dbg_gnt    (dbg_gnt[k]),
      .dbg_rvalid (dbg_rvalid[k]),
      .rdata      (rdata[k]),
      .pipe_stall (pipe_stall[k]),
      .mem_en     (mem_en[k]),
      .mem_we     (mem_we[k]),
      .mem_be     (mem_be[k]),
      .mem_addr   (mem_addr[k]),
      .mem_wdata  (mem_wdata[k]),
      .mem_rdata  (mem_rdata[k])
    );

    // Behavioural SRAM with byte writes and an RL-stage read pipeline.
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rpipe [RL];
    always @(posedge clk) begin
      if (mem_en[k] && mem_we[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[k][b]) mem[mem_addr[k]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
        end
      end
      rpipe[0] <= (mem_en[k] && !mem_we[k]) ? mem[mem_addr[k]] : 32'h0BAD_0BAD;
      for (int i = 1; i < int'(RL); i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata[k] = rpipe[RL-1];
  end

  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_lock;
    logic [2:0]    gnt1;   // {dbg, d, if} expected on latency-1 instance
    logic [2:0]    gnt2;   // same for latency-2 instance
    logic          stall1;
    logic          stall2;
    logic [DW-1:0] rd;     // data expected back if the winner is a read
  } vec_t;

  typedef struct {
    int         due;
    logic [2:0] onehot;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t sb0[$];
  rsp_t sb1[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Compare response outputs of instance k against the scoreboard head.
  task automatic mon(input int k);
    rsp_t       e;
    logic [2:0] exp_rv;
    logic [DW-1:0] exp_d;
    exp_rv = G_NO;
    exp_d  = '0;
    if (k == 0 && sb0.size() > 0 && sb0[0].due == cyc) begin
      e = sb0.pop_front();
      exp_rv = e.onehot;
      exp_d  = e.data;
    end
    if (k == 1 && sb1.size() > 0 && sb1[0].due == cyc) begin
      e = sb1.pop_front();
      exp_rv = e.onehot;
      exp_d  = e.data;
    end
    chk($sformatf("rvalid%0d", k), 64'({dbg_rvalid[k], d_rvalid[k], if_rvalid[k]}), 64'(exp_rv));
    if (exp_rv != G_NO) chk($sformatf("rdata%0d", k), 64'(rdata[k]), 64'(exp_d));
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Drive one cycle of stimulus, check grants/stall/SRAM bus, queue any read response.
  task automatic apply(input vec_t v, input string nm);
    logic [2:0] eg;
    logic       es, e_en, e_we;
    logic [3:0] e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [47:0] exp_b, got_b;
    rsp_t r;
    if_req = v.if_req;   if_addr = v.if_addr;
    d_req = v.d_req;     d_we = v.d_we;     d_be = v.d_be;
    d_addr = v.d_addr;   d_wdata = v.d_wdata;
    dbg_req = v.dbg_req; dbg_we = v.dbg_we; dbg_addr = v.dbg_addr;
    dbg_wdata = v.dbg_wdata; dbg_lock = v.dbg_lock;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      eg = (k == 0) ? v.gnt1 : v.gnt2;
      es = (k == 0) ? v.stall1 : v.stall2;
      chk($sformatf("%s gnt%0d", nm, k), 64'({dbg_gnt[k], d_gnt[k], if_gnt[k]}), 64'(eg));
      chk($sformatf("%s stall%0d", nm, k), 64'(pipe_stall[k]), 64'(es));
      e_en = (eg != G_NO); e_we = 1'b0; e_be = BE_ALL; e_addr = '0; e_wd = '0;
      if (eg == G_IF) begin
        e_addr = v.if_addr;
      end else if (eg == G_D) begin
        e_we = v.d_we; e_be = v.d_be; e_addr = v.d_addr; e_wd = v.d_wdata;
      end else if (eg == G_DBG) begin
        e_we = v.dbg_we; e_addr = v.dbg_addr; e_wd = v.dbg_wdata;
      end
      if (e_en) begin
        exp_b = {e_en, e_we, e_be, e_addr, e_wd & {DW{e_we}}};
        got_b = {mem_en[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k] & {DW{mem_we[k]}}};
      end else begin
        exp_b = '0;
        got_b = {47'b0, mem_en[k]};
      end
      chk($sformatf("%s membus%0d", nm, k), 64'(got_b), 64'(exp_b));
      if (e_en && !e_we) begin
        r.due = cyc + k + 1;
        r.onehot = eg;
        r.data = v.rd;
        if (k == 0) sb0.push_back(r);
        else sb1.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s outs%0d", nm, k),
          64'({if_gnt[k], d_gnt[k], dbg_gnt[k], if_rvalid[k], d_rvalid[k], dbg_rvalid[k],
               pipe_stall[k], mem_en[k]}), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[14];
  vec_t v;

  initial begin
    // if  ifa    d  we be     da      dwdata         g  gwe ga      gwdata        lk g1     g2     s1 s2 rd
    tbl[0]  = '{0, 10'h0, 0, 0, 4'h0, 10'h0,  32'h0,         0, 0, 10'h0,  32'h0,         0, G_NO,  G_NO,  0, 0, 32'h0};
    tbl[1]  = '{0, 10'h0, 0, 0, 4'h0, 10'h0,  32'h0,         1, 1, 10'h004, 32'h8C010000, 0, G_DBG, G_DBG, 0, 0, 32'h0};
    tbl[2]  = '{0, 10'h0, 0, 0, 4'h0, 10'h0,  32'h0,         1, 1, 10'h030, 32'hA5A50030, 0, G_DBG, G_DBG, 0, 0, 32'h0};
    tbl[3]  = '{1, 10'h004, 0, 0, 4'h0, 10'h0, 32'h0,        0, 0, 10'h0,  32'h0,         0, G_IF,  G_IF,  0, 0, 32'h8C010000};
    tbl[4]  = '{1, 10'h004, 1, 1, 4'hF, 10'h010, 32'hDEADBEEF, 0, 0, 10'h0, 32'h0,        0, G_D,   G_D,   1, 1, 32'h0};
    tbl[5]  = '{1, 10'h004, 1, 0, 4'hF, 10'h010, 32'h0,      1, 0, 10'h030, 32'h0,        0, G_DBG, G_DBG, 1, 1, 32'hA5A50030};
    tbl[6]  = '{0, 10'h0, 1, 0, 4'hF, 10'h010, 32'h0,        0, 0, 10'h0,  32'h0,         0, G_D,   G_D,   0, 0, 32'hDEADBEEF};
    tbl[7]  = '{0, 10'h0, 1, 1, 4'h0, 10'h010, 32'hFFFFFFFF, 0, 0, 10'h0,  32'h0,         0, G_D,   G_D,   0, 0, 32'h0};
    tbl[8]  = '{0, 10'h0, 1, 0, 4'hF, 10'h010, 32'h0,        0, 0, 10'h0,  32'h0,         0, G_D,   G_D,   0, 0, 32'hDEADBEEF};
    tbl[9]  = '{0, 10'h0, 1, 1, 4'h3, 10'h010, 32'h00001234, 0, 0, 10'h0,  32'h0,         0, G_D,   G_D,   0, 0, 32'h0};
    tbl[10] = '{0, 10'h0, 1, 0, 4'hF, 10'h010, 32'h0,        0, 0, 10'h0,  32'h0,         0, G_D,   G_D,   0, 0, 32'hDEAD1234};
    tbl[11] = '{0, 10'h0, 1, 0, 4'hF, 10'h030, 32'h0,        1, 1, 10'h021, 32'h00000055, 0, G_DBG, G_DBG, 1, 1, 32'h0};
    tbl[12] = '{1, 10'h004, 1, 0, 4'hF, 10'h021, 32'h0,      0, 0, 10'h0,  32'h0,         0, G_D,   G_D,   1, 1, 32'h00000055};
    tbl[13] = '{1, 10'h004, 0, 0, 4'h0, 10'h0, 32'h0,        0, 0, 10'h0,  32'h0,         0, G_IF,  G_IF,  0, 0, 32'h8C010000};

    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;

    // Reset state: requests present but nothing granted or stalled.
    @(negedge clk);
    if_req = 1; d_req = 1; dbg_req = 1;
    @(negedge clk);
    chk_quiet("reset");
    if_req = 0; d_req = 0; dbg_req = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Priority, muxing, byte enables and read-back.
    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back fetches, each answered one/two cycles later.
    for (int i = 0; i < 4; i++) apply(tbl[13], $sformatf("fetch%0d", i));

    // Starvation guard: data wins four times, then fetch once, then data again.
    for (int i = 0; i < 10; i++) begin
      v = '{1, 10'h004, 1, 1, 4'hF, 10'h040, 32'hCAFE0040, 0, 0, 10'h0, 32'h0, 0,
            G_D, G_D, 1, 1, 32'h8C010000};
      if (i == 4 || i == 9) begin
        v.gnt1 = G_IF;
        v.gnt2 = G_IF;
      end
      apply(v, $sformatf("starve%0d", i));
    end

    // Debug lock: latency-1 instance locks at once, latency-2 drains one cycle.
    v = '{0, 10'h0, 1, 0, 4'hF, 10'h021, 32'h0, 0, 0, 10'h0, 32'h0, 0,
          G_D, G_D, 0, 0, 32'h00000055};
    apply(v, "lock_rd");
    v = '{0, 10'h0, 0, 0, 4'h0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0, 1,
          G_NO, G_NO, 0, 0, 32'h0};
    apply(v, "lock_raise");
    v = '{0, 10'h0, 1, 0, 4'hF, 10'h010, 32'h0, 1, 1, 10'h020, 32'h12345678, 1,
          G_DBG, G_NO, 1, 1, 32'h0};
    apply(v, "lock_drain");
    v.gnt2 = G_DBG;
    apply(v, "lock_held");
    v = '{0, 10'h0, 1, 0, 4'hF, 10'h020, 32'h0, 0, 0, 10'h0, 32'h0, 0,
          G_NO, G_NO, 1, 1, 32'h0};
    apply(v, "lock_drop");
    v = '{0, 10'h0, 1, 0, 4'hF, 10'h020, 32'h0, 0, 0, 10'h0, 32'h0, 0,
          G_D, G_D, 0, 0, 32'h12345678};
    apply(v, "lock_arb");

    // Reset right after a fetch grant: its response must never appear.
    apply(tbl[13], "rst_fetch");
    rst_n = 1'b0;
    sb0.delete();
    sb1.delete();
    if_req = 1; d_req = 1; dbg_req = 1;
    @(negedge clk);
    chk_quiet("rst_mid0");
    @(negedge clk);
    chk_quiet("rst_mid1");
    if_req = 0; d_req = 0; dbg_req = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    v = '{1, 10'h004, 1, 1, 4'hF, 10'h050, 32'h00000001, 0, 0, 10'h0, 32'h0, 0,
          G_D, G_D, 1, 1, 32'h0};
    apply(v, "post_rst");
    apply(tbl[13], "post_rst_if");
    apply(tbl[0], "idle0");
    apply(tbl[0], "idle1");

    @(negedge clk);
    chk("sb_left0", 64'(sb0.size()), 64'(0));
    chk("sb_left1", 64'(sb1.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
